buffer_64_to_512: RTL

//  Write-side companion to the 512->64 read splitter: packs 64-bit accelerator result words into
//  512-bit lines for the memory-write interface. A lane counter assembles each line, and a small

---
 rtl/buffer_64_to_512.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/buffer_64_to_512.sv
// buffer_64_to_512
//   Packs 64-bit result words into 512-bit lines for the memory-write side.
//   A lane counter assembles each line. Completed or flushed lines go into a
//   small show-ahead FIFO. The first word of a line lands in bits [63:0], and
//   lane i lands in bits [i*64+63:i*64].
// Ports
//   clk, rst (sync, active-low), clr (sync, active-high, same effect as rst)
//   data_in/wr_enable : word input; a write is dropped while write_blocked=1
//   flush             : pushes the partial line, with unused lanes zero
//   data_out/lane_valid : FIFO head line and its lane mask (zero when empty)
//   rd_enable         : pops the head line; ignored while the FIFO is empty
//   empty/full/level  : registered FIFO status
//   write_blocked     : full, or a flush is waiting for FIFO space
//   overflow          : sticky; a write was attempted while blocked
module buffer_64_to_512 #(
    parameter int DEPTH = 4,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [63:0]      data_in,
    input  logic             wr_enable,
    input  logic             flush,
    output logic [511:0]     data_out,
    output logic [7:0]       lane_valid,
    input  logic             rd_enable,
    output logic             empty,
    output logic             full,
    output logic             write_blocked,
    output logic [LVL_W-1:0] level,
    output logic             overflow
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, FILL, FLUSH_WAIT} state_t;

    state_t           state, state_d;
    logic [511:0]     asm_line, line_w, line_d, push_line;
    logic [7:0]       asm_mask, mask_w, mask_d, push_mask;
    logic [2:0]       idx, idx_w, idx_d;
    logic [519:0]     mem [DEPTH];
    logic [519:0]     head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level_d;
    logic             clear, wr_acc, pop, push;

    assign clear         = !rst || clr;
    assign write_blocked = full || (state == FLUSH_WAIT);
    assign wr_acc        = wr_enable && !write_blocked;
    assign pop           = rd_enable && !empty;

    // The next-state and push logic works on the assembler after the current
    // word is merged (line_w/mask_w). A write and a flush in the same cycle
    // therefore flush a line that includes that word.
    always_comb begin
        line_w    = asm_line;
        mask_w    = asm_mask;
        idx_w     = idx;
        state_d   = state;
        push      = 1'b0;
        push_line = '0;
        push_mask = '0;
        if (wr_acc) begin
            line_w[{idx, 6'd0} +: 64] = data_in;
            mask_w[idx]               = 1'b1;
            idx_w                     = idx + 3'd1;
        end
        line_d = line_w;
        mask_d = mask_w;
        idx_d  = idx_w;
        case (state)
            IDLE, FILL: begin
                // A write is never accepted while full, so a completed line
                // always has room in the FIFO.
                if (wr_acc && idx == 3'd7) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end else if (flush && mask_w != 8'h00) begin
                    if (!full) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = FLUSH_WAIT;
                    end
                end else if (mask_w != 8'h00) begin
                    state_d = FILL;
                end
            end
            FLUSH_WAIT: begin
                // A pop on the same edge frees the slot this push needs.
                if (!full || pop) begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (push) begin
            push_line = line_w;
            push_mask = mask_w;
            line_d    = '0;
            mask_d    = '0;
            idx_d     = '0;
        end
    end

    assign level_d = level + LVL_W'(push) - LVL_W'(pop);

    always_ff @(posedge clk) begin
        if (clear) begin
            state    <= IDLE;
            asm_line <= '0;
            asm_mask <= '0;
            idx      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            empty    <= 1'b1;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_d;
            asm_line <= line_d;
            asm_mask <= mask_d;
            idx      <= idx_d;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            level    <= level_d;
            empty    <= (level_d == '0);
            full     <= (level_d == LVL_W'(DEPTH));
            if (wr_enable && write_blocked) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= {push_mask, push_line};
    end

    // The FIFO storage is not reset, so the head is masked while empty.
    assign head = mem[rd_ptr];

    always_comb begin
        data_out   = '0;
        lane_valid = '0;
        if (!empty) begin
            data_out   = head[511:0];
            lane_valid = head[519:512];
        end
    end
endmodule
